// File: rtl/wb_bcd_pkg.sv
// Shared definitions for the wb_BCD peripheral: default geometry, converter
// FSM encoding and the decimal range helper.
package wb_bcd_pkg;

  localparam int BCD_DIGITS = 8;
  localparam int BCD_BIN_W  = 26;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } bcd_state_e;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic longint unsigned bcd_max(input int digits);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit shift-and-add-3 correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock. Feeds the packed
// digit vector to the 7-segment anode scanner; results hold until the next done.
module bin2bcd_seq
  import wb_bcd_pkg::*;
#(
  parameter int BIN_W  = BCD_BIN_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int                BCD_W     = 4 * DIGITS;
  localparam int                CNT_W     = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIN_W - 1);
  localparam logic [63:0]       BCD_LIMIT = bcd_max(DIGITS);
  localparam logic [BCD_W-1:0]  BCD_SAT   = {DIGITS{4'h9}};

  bcd_state_e         state_q, state_d;
  logic [BIN_W-1:0]   shift_bin;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_q;

  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_shl;
  logic [BIN_W-1:0]   bin_shl;
  logic               bin_big;
  logic               unused_top_carry;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scratch[4*g +: 4]),
      .q (scratch_adj[4*g +: 4])
    );
  end

  // The top digit's corrected MSB falls off the shift; it can only be set for
  // out-of-range inputs, which are saturated anyway.
  assign unused_top_carry = scratch_adj[BCD_W-1];
  assign scratch_shl      = {scratch_adj[BCD_W-2:0], shift_bin[BIN_W-1]};
  assign bin_shl          = {shift_bin[BIN_W-2:0], 1'b0};
  assign bin_big          = 64'(bin_in) > BCD_LIMIT;
  assign busy             = (state_q == ST_SHIFT);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)       state_d = ST_SHIFT;
      ST_SHIFT: if (cnt == '0)   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every datapath register is reset too, so an aborted conversion leaves no stale digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_bin <= '0;
      scratch   <= '0;
      cnt       <= '0;
      ovf_q     <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            shift_bin <= bin_in;
            scratch   <= '0;
            cnt       <= CNT_LAST;
            ovf_q     <= bin_big;
          end
        end
        ST_SHIFT: begin
          shift_bin <= bin_shl;
          scratch   <= scratch_shl;
          cnt       <= cnt - 1'b1;
          if (cnt == '0) begin
            bcd_out  <= ovf_q ? BCD_SAT : scratch_shl;
            overflow <= ovf_q;
            done     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
